chromatic_sequencer: RTL and testbench

//  Control front-end for the chromatic RGB matrix driver. Debounces the raw colour and dim

---
 rtl/chromatic_sequencer_if.sv | 37 +++
 rtl/chromatic_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_chromatic_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/chromatic_sequencer_if.sv
// Button/brightness bus between the chromatic sequencer and whatever drives its
// buttons and consumes its outputs. The auto_en line exists only when the
// AUTO_CYCLE_EN macro is defined.
interface chromatic_sequencer_if #(
  parameter int PWM_BITS = 8
);
  logic                color_btn_n;
  logic                dim_btn_n;
  logic                up_down;
`ifdef AUTO_CYCLE_EN
  logic                auto_en;
`endif
  logic                f_edge;
  logic                pwm_out;
  logic [PWM_BITS-1:0] level;
  logic [2:0]          color_idx;

`ifdef AUTO_CYCLE_EN
  modport master (
    output color_btn_n, dim_btn_n, up_down, auto_en,
    input  f_edge, pwm_out, level, color_idx
  );
  modport slave (
    input  color_btn_n, dim_btn_n, up_down, auto_en,
    output f_edge, pwm_out, level, color_idx
  );
`else
  modport master (
    output color_btn_n, dim_btn_n, up_down,
    input  f_edge, pwm_out, level, color_idx
  );
  modport slave (
    input  color_btn_n, dim_btn_n, up_down,
    output f_edge, pwm_out, level, color_idx
  );
`endif
endinterface

// File: rtl/chromatic_sequencer.sv
// Control front-end for the chromatic RGB matrix driver: debounces the colour and
// dim buttons, emits the one-cycle colour-advance pulse f_edge, tracks the driver
// colour index and generates the PWM brightness gate (pwm_out = 1 -> LEDs off).
// Optional feature: define AUTO_CYCLE_EN to add an auto-advance timer gated by auto_en.
module chromatic_sequencer #(
  parameter int DEB_CYCLES  = 500000,
  parameter int PWM_BITS    = 8,
  parameter int STEP        = 16,
  parameter int AUTO_CYCLES = 50000000
) (
  input logic                  clk,
  input logic                  rst_n,
  chromatic_sequencer_if.slave bus
);

  localparam int                DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS + 1)'(STEP);

  typedef enum logic [1:0] {
    DEB_IDLE,
    DEB_CHK_PRESS,
    DEB_HELD,
    DEB_CHK_REL
  } deb_state_t;

  // Button index 0 = colour, 1 = dim.
  logic [1:0]       btn_raw_n;
  logic [1:0]       sync_meta;
  logic [1:0]       sync_q;
  deb_state_t       deb_state     [2];
  deb_state_t       deb_state_nxt [2];
  logic [DEB_W-1:0] deb_cnt       [2];
  logic [DEB_W-1:0] deb_cnt_nxt   [2];
  logic [1:0]       accept;

  logic                advance;
  logic                auto_tick;
  logic                f_edge_q;
  logic [2:0]          color_idx_q;
  logic [PWM_BITS-1:0] pending;
  logic [PWM_BITS-1:0] pending_nxt;
  logic [PWM_BITS:0]   sum_up;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_out_q;

  assign btn_raw_n = {bus.dim_btn_n, bus.color_btn_n};

  // Two-flop synchronisers; idle level of an active-low button is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values; blocking here would collapse the synchroniser to one stage.
      sync_meta <= btn_raw_n;
      sync_q    <= sync_meta;
    end
  end

  // Debounce state and counter registers for both buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        deb_state[i] <= DEB_IDLE;
        deb_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        deb_state[i] <= deb_state_nxt[i];
        deb_cnt[i]   <= deb_cnt_nxt[i];
      end
    end
  end

  // Debounce next-state: a press is accepted once, after DEB_CYCLES stable-low cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case leaves it unassigned and no latch is inferred.
      deb_state_nxt[i] = deb_state[i];
      deb_cnt_nxt[i]   = deb_cnt[i];
      accept[i]        = 1'b0;
      case (deb_state[i])
        DEB_IDLE: begin
          if (!sync_q[i]) begin
            deb_state_nxt[i] = DEB_CHK_PRESS;
            deb_cnt_nxt[i]   = '0;
          end
        end
        DEB_CHK_PRESS: begin
          if (sync_q[i]) begin
            deb_state_nxt[i] = DEB_IDLE;
          end else if (deb_cnt[i] == DEB_LAST) begin
            deb_state_nxt[i] = DEB_HELD;
            accept[i]        = 1'b1;
          end else begin
            deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
          end
        end
        DEB_HELD: begin
          if (sync_q[i]) begin
            deb_state_nxt[i] = DEB_CHK_REL;
            deb_cnt_nxt[i]   = '0;
          end
        end
        DEB_CHK_REL: begin
          if (!sync_q[i]) begin
            deb_state_nxt[i] = DEB_HELD;
          end else if (deb_cnt[i] == DEB_LAST) begin
            deb_state_nxt[i] = DEB_IDLE;
          end else begin
            deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
          end
        end
        default: deb_state_nxt[i] = DEB_IDLE;
      endcase
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam int               AUTO_W    = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
  logic [AUTO_W-1:0] auto_timer;

  assign auto_tick = bus.auto_en && (auto_timer == AUTO_LAST);

  // Auto-advance timer; cleared whenever an advance is issued so a manual press
  // restarts the period, and held at zero while auto_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_timer <= '0;
    end else if (!bus.auto_en || advance) begin
      auto_timer <= '0;
    end else begin
      auto_timer <= auto_timer + 1'b1;
    end
  end
`else
  assign auto_tick = 1'b0;
`endif

  // Coincident sources merge into a single advance.
  assign advance = accept[0] | auto_tick;

  // Registered colour-advance pulse and mirrored driver colour index (RED..BLACK).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_edge_q    <= 1'b0;
      color_idx_q <= 3'd0;
    end else begin
      f_edge_q <= advance;
      if (f_edge_q) begin
        color_idx_q <= (color_idx_q == 3'd6) ? 3'd0 : color_idx_q + 3'd1;
      end
    end
  end

  // Saturating brightness step; successive accepts build on the pending value.
  always_comb begin
    sum_up      = {1'b0, pending} + STEP_EXT;
    pending_nxt = pending;
    if (accept[1]) begin
      if (bus.up_down) begin
        pending_nxt = (sum_up > {1'b0, LVL_MAX}) ? LVL_MAX : sum_up[PWM_BITS-1:0];
      end else begin
        pending_nxt = ({1'b0, pending} < STEP_EXT) ? '0 : pending - STEP_EXT[PWM_BITS-1:0];
      end
    end
  end

  // PWM counter and gate; the active level only changes at the counter wrap so
  // one PWM period always uses a single level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= LVL_MAX;
      level_q   <= LVL_MAX;
      pwm_cnt   <= '0;
      pwm_out_q <= 1'b1;
    end else begin
      pending   <= pending_nxt;
      pwm_cnt   <= pwm_cnt + 1'b1;
      pwm_out_q <= (pwm_cnt >= level_q);
      if (pwm_cnt == LVL_MAX) begin
        level_q <= pending;
      end
    end
  end

  assign bus.f_edge    = f_edge_q;
  assign bus.pwm_out   = pwm_out_q;
  assign bus.level     = level_q;
  assign bus.color_idx = color_idx_q;

endmodule

// File: tb/tb_chromatic_sequencer.sv
// Directed bench for chromatic_sequencer with DEB_CYCLES=4, PWM_BITS=4, STEP=4,
// AUTO_CYCLES=20. Auto-advance scenarios run only when AUTO_CYCLE_EN is defined.
module tb_chromatic_sequencer;

  localparam int DEB  = 4;
  localparam int PB   = 4;
  localparam int STP  = 4;
  localparam int AUTO = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  chromatic_sequencer_if #(.PWM_BITS(PB)) bus ();

  chromatic_sequencer #(
    .DEB_CYCLES (DEB),
    .PWM_BITS   (PB),
    .STEP       (STP),
    .AUTO_CYCLES(AUTO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count of cycles with f_edge high (one per accepted advance).
  int edge_cnt = 0;
  always @(negedge clk) begin
    if (bus.f_edge === 1'b1) edge_cnt <= edge_cnt + 1;
  end

  // Reference PWM counter: any level change must land right after a wrap (m_cnt==0).
  logic [PB-1:0] m_cnt;
  logic [PB-1:0] last_level = '1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= '0;
    else        m_cnt <= m_cnt + 1'b1;
  end
  always @(negedge clk) begin
    if (rst_n && (bus.level !== last_level)) check("level_at_wrap", m_cnt, 0);
    last_level <= bus.level;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_color(input int low, input int high);
    bus.color_btn_n = 1'b0;
    cycles(low);
    bus.color_btn_n = 1'b1;
    cycles(high);
  endtask

  task automatic press_dim(input int low, input int high);
    bus.dim_btn_n = 1'b0;
    cycles(low);
    bus.dim_btn_n = 1'b1;
    cycles(high);
  endtask

  task automatic wait_fedge(input int budget, output bit found, output int waited);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.f_edge === 1'b1) found = 1'b1;
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.pwm_out === 1'b0) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   found;
    int   w;
    int   e0;
    int   n;
    logic [PB-1:0] exp_lvl [5];
    exp_lvl[0] = 4'd11; exp_lvl[1] = 4'd7; exp_lvl[2] = 4'd3;
    exp_lvl[3] = 4'd0;  exp_lvl[4] = 4'd0;

    bus.color_btn_n = 1'b1;
    bus.dim_btn_n   = 1'b1;
    bus.up_down     = 1'b1;
`ifdef AUTO_CYCLE_EN
    bus.auto_en     = 1'b0;
`endif
    rst_n = 1'b0;
    cycles(3);
    check("rst_f_edge", bus.f_edge, 0);
    check("rst_pwm_out", bus.pwm_out, 1);
    check("rst_level", bus.level, 15);
    check("rst_color_idx", bus.color_idx, 0);
    rst_n = 1'b1;
    cycles(2);

    // Single clean press, then a 3-cycle glitch that must be rejected.
    press_color(10, 10);
    cycles(2);
    check("press_edges", edge_cnt, 1);
    check("press_idx", bus.color_idx, 1);
    press_color(3, 10);
    cycles(2);
    check("glitch_edges", edge_cnt, 1);
    check("glitch_idx", bus.color_idx, 1);
    count_low(n);
    check("pwm_on_level15", n, 15);

    // Dim once (15 -> 11), then reset while f_edge is high mid-press.
    bus.up_down = 1'b0;
    press_dim(10, 10);
    cycles(16);
    check("dim_first_level", bus.level, 11);
    bus.color_btn_n = 1'b0;
    wait_fedge(20, found, w);
    check("pre_reset_edge_found", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_f_edge", bus.f_edge, 0);
    check("midrst_pwm_out", bus.pwm_out, 1);
    check("midrst_level", bus.level, 15);
    check("midrst_color_idx", bus.color_idx, 0);
    bus.color_btn_n = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // Seven presses walk color_idx 1..6 then wrap to 0, one pulse each.
    e0 = edge_cnt;
    for (int i = 0; i < 7; i++) begin
      press_color(10, 10);
      check("seq_idx", bus.color_idx, (i + 1) % 7);
      check("seq_edges", edge_cnt, e0 + i + 1);
    end

    // Brightening at max saturates; then five dims 11,7,3,0,0.
    bus.up_down = 1'b1;
    press_dim(10, 10);
    cycles(16);
    check("up_sat_level", bus.level, 15);
    bus.up_down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press_dim(10, 10);
      cycles(16);
      check("dim_level", bus.level, exp_lvl[i]);
      if (i == 2) begin
        count_low(n);
        check("pwm_on_level3", n, 3);
      end
    end
    count_low(n);
    check("pwm_on_level0", n, 0);
    bus.up_down = 1'b1;
    press_dim(10, 10);
    cycles(16);
    check("up_from_zero", bus.level, 4);

`ifdef AUTO_CYCLE_EN
    // Auto period, manual press restarting it, and a press coincident with a tick.
    bus.auto_en = 1'b1;
    wait_fedge(40, found, w);
    check("auto_first_found", found, 1);
    wait_fedge(40, found, w);
    check("auto_period", w, 20);
    cycles(5);
    bus.color_btn_n = 1'b0;
    wait_fedge(20, found, w);
    check("manual_latency", w, 7);
    bus.color_btn_n = 1'b1;
    wait_fedge(40, found, w);
    check("auto_after_manual", w, 20);
    cycles(13);
    bus.color_btn_n = 1'b0;
    wait_fedge(20, found, w);
    check("coincident_at_tick", w, 7);
    @(negedge clk);
    check("coincident_single", bus.f_edge, 0);
    bus.color_btn_n = 1'b1;
    wait_fedge(40, found, w);
    check("auto_after_coincident", w, 19);
    bus.auto_en = 1'b0;
    cycles(2);
    e0 = edge_cnt;
    cycles(30);
    check("auto_disabled", edge_cnt, e0);
`endif

    // Button held through reset release: sync 2 + idle 1 + 4 debounce cycles.
    bus.color_btn_n = 1'b0;
    rst_n = 1'b0;
    cycles(3);
    e0 = edge_cnt;
    rst_n = 1'b1;
    wait_fedge(30, found, w);
    check("held_rst_found", found, 1);
    check("held_rst_latency", w, 7);
    cycles(20);
    check("held_rst_once", edge_cnt, e0 + 1);
    bus.color_btn_n = 1'b1;
    cycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
